// File: rtl/dither_print_tx.sv
// Streams the 1-bit dithered frame buffer to the printer UART. It sends a raster header,
// then the frame row-major, 8 pixels per byte with the first pixel in the MSB.
module dither_print_tx #(
   parameter int H_PIXELS   = 320,
   parameter int V_PIXELS   = 240,
   parameter int RD_LATENCY = 2,
   parameter bit INVERT     = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        start_in,
   output logic        busy_out,
   output logic        done_out,
   output logic [16:0] rd_addr_out,
   input  logic        rd_data_in,
   output logic [7:0]  byte_out,
   output logic        byte_valid_out,
   input  logic        byte_ready_in,
   output logic [2:0]  state_dbg_out
);

   // Byte handshake: a byte moves only on a cycle where byte_valid_out && byte_ready_in.
   // Once byte_valid_out is raised, byte_out and byte_valid_out stay put until that transfer.

   localparam logic [15:0] X_BYTES   = 16'(H_PIXELS / 8);
   localparam logic [15:0] Y_LINES   = 16'(V_PIXELS);
   localparam logic [16:0] TOTAL_PIX = 17'(H_PIXELS * V_PIXELS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEADER = 3'd1,
      S_FETCH  = 3'd2,
      S_SEND   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                  state;
   logic [16:0]             base;
   logic [2:0]              hdr_idx;
   logic [3:0]              issue_cnt;
   logic [2:0]              cap_cnt;
   logic [7:0]              shift;
   logic                    addr_vld;
   logic [RD_LATENCY-1:0]   vld_pipe;

   logic                    capture;
   logic [7:0]              shift_next;
   logic [16:0]             base_next;

   function automatic logic [7:0] header_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h1D;
         3'd1:    b = 8'h76;
         3'd2:    b = 8'h30;
         3'd3:    b = 8'h00;
         3'd4:    b = X_BYTES[7:0];
         3'd5:    b = X_BYTES[15:8];
         3'd6:    b = Y_LINES[7:0];
         default: b = Y_LINES[15:8];
      endcase
      return b;
   endfunction

   // vld_pipe tracks which cycles of rd_data_in belong to an address we issued.
   assign capture       = vld_pipe[RD_LATENCY-1];
   assign shift_next    = {shift[6:0], rd_data_in};
   assign base_next     = base + 17'd8;
   assign state_dbg_out = state;

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state          <= S_IDLE;
         busy_out       <= 1'b0;
         done_out       <= 1'b0;
         byte_valid_out <= 1'b0;
         byte_out       <= '0;
         rd_addr_out    <= '0;
         base           <= '0;
         hdr_idx        <= '0;
         issue_cnt      <= '0;
         cap_cnt        <= '0;
         shift          <= '0;
         addr_vld       <= 1'b0;
         vld_pipe       <= '0;
      end else begin
         vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(addr_vld);
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  state          <= S_HEADER;
                  busy_out       <= 1'b1;
                  hdr_idx        <= '0;
                  base           <= '0;
                  cap_cnt        <= '0;
                  shift          <= '0;
                  byte_out       <= header_byte(3'd0);
                  byte_valid_out <= 1'b1;
               end
            end
            S_HEADER: begin
               if (byte_ready_in) begin
                  if (hdr_idx == 3'd7) begin
                     state          <= S_FETCH;
                     byte_valid_out <= 1'b0;
                     rd_addr_out    <= base;
                     addr_vld       <= 1'b1;
                     issue_cnt      <= 4'd1;
                  end else begin
                     hdr_idx  <= hdr_idx + 3'd1;
                     byte_out <= header_byte(hdr_idx + 3'd1);
                  end
               end
            end
            S_FETCH: begin
               if (issue_cnt != 4'd8) begin
                  rd_addr_out <= base + 17'(issue_cnt);
                  issue_cnt   <= issue_cnt + 4'd1;
               end else begin
                  addr_vld <= 1'b0;
               end
               if (capture) begin
                  shift   <= shift_next;
                  cap_cnt <= cap_cnt + 3'd1;
                  if (cap_cnt == 3'd7) begin
                     state          <= S_SEND;
                     byte_out       <= INVERT ? ~shift_next : shift_next;
                     byte_valid_out <= 1'b1;
                  end
               end
            end
            S_SEND: begin
               if (byte_ready_in) begin
                  byte_valid_out <= 1'b0;
                  base           <= base_next;
                  if (base_next == TOTAL_PIX) begin
                     state    <= S_DONE;
                     done_out <= 1'b1;
                     busy_out <= 1'b0;
                  end else begin
                     state       <= S_FETCH;
                     rd_addr_out <= base_next;
                     addr_vld    <= 1'b1;
                     issue_cnt   <= 4'd1;
                  end
               end
            end
            S_DONE: begin
               done_out <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dither_print_tx.sv
// Randomized scoreboard bench for dither_print_tx on a reduced 16x300 frame,
// which gives a two-byte line count in the header.
module tb_dither_print_tx;

   localparam int H   = 16;
   localparam int V   = 300;
   localparam int PIX = H * V;
   localparam int NB  = 8 + (H / 8) * V;

   logic        clk = 1'b0;
   logic        rst_in_n = 1'b0;
   logic        start_in = 1'b0;
   logic        busy_out, done_out;
   logic [16:0] rd_addr_out;
   logic        rd_data_in = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_valid_out;
   logic        byte_ready_in = 1'b1;
   logic [2:0]  state_dbg_out;

   dither_print_tx #(.H_PIXELS(H), .V_PIXELS(V), .RD_LATENCY(2), .INVERT(1'b1)) dut (
      .clk_in(clk), .rst_in_n(rst_in_n), .start_in(start_in),
      .busy_out(busy_out), .done_out(done_out), .rd_addr_out(rd_addr_out),
      .rd_data_in(rd_data_in), .byte_out(byte_out), .byte_valid_out(byte_valid_out),
      .byte_ready_in(byte_ready_in), .state_dbg_out(state_dbg_out)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         xfer_cnt = 0;
   int         done_cnt = 0;
   int         ready_pct = 100;
   int         pix_mode = 0;
   bit         rnd_img[PIX];
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit pixel(input int a);
      case (pix_mode)
         0:       return a[0];
         1:       return 1'b1;
         2:       return (a == 8);
         default: return (a < PIX) ? rnd_img[a] : 1'b0;
      endcase
   endfunction

   // Frame buffer with a two-cycle read latency.
   logic d1 = 1'b0;
   always @(posedge clk) begin
      d1         <= pixel(int'(rd_addr_out));
      rd_data_in <= d1;
   end

   always @(posedge clk) begin
      #1;
      byte_ready_in = ($urandom_range(0, 99) < ready_pct);
   end

   // Reference stream: header, then 8 pixels per byte, first pixel in the MSB, inverted.
   task automatic build_expected();
      logic [7:0] raw;
      exp_q.delete();
      exp_q.push_back(8'h1D);
      exp_q.push_back(8'h76);
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'((H / 8) % 256));
      exp_q.push_back(8'((H / 8) / 256));
      exp_q.push_back(8'(V % 256));
      exp_q.push_back(8'(V / 256));
      for (int b = 0; b < PIX / 8; b++) begin
         raw = '0;
         for (int k = 0; k < 8; k++) raw[7-k] = pixel(b * 8 + k);
         exp_q.push_back(~raw);
      end
   endtask

   // Scoreboard monitor.
   logic       prev_v = 1'b0, prev_r = 1'b0, last_xfer = 1'b0, cur = 1'b0;
   logic [7:0] prev_b = '0;
   logic [7:0] e;
   always @(negedge clk) begin
      if (!rst_in_n) begin
         prev_v = 1'b0;
         prev_r = 1'b0;
         last_xfer = 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("valid_hold", {31'd0, byte_valid_out}, 32'd1);
            chk("byte_hold", {24'd0, byte_out}, {24'd0, prev_b});
         end
         if (byte_valid_out) chk("busy_with_valid", {31'd0, busy_out}, 32'd1);
         if (done_out) begin
            chk("done_after_last", {31'd0, last_xfer}, 32'd1);
            chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
            done_cnt++;
         end
         cur = byte_valid_out && byte_ready_in;
         if (cur) begin
            if (exp_q.size() == 0) begin
               chk("extra_byte", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("stream_byte", {24'd0, byte_out}, {24'd0, e});
            end
            xfer_cnt++;
         end
         last_xfer = cur;
         prev_v = byte_valid_out;
         prev_r = byte_ready_in;
         prev_b = byte_out;
      end
   end

   task automatic start_frame();
      build_expected();
      @(posedge clk); #1 start_in = 1'b1;
      @(posedge clk); #1 start_in = 1'b0;
      chk("valid_after_start", {31'd0, byte_valid_out}, 32'd1);
      chk("busy_after_start", {31'd0, busy_out}, 32'd1);
   endtask

   task automatic wait_done(input int done0, input int xfer0);
      int cyc = 0;
      while (done_cnt == done0 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      if (done_cnt == done0) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy_out}, 32'd0);
      chk("transfer_count", 32'(xfer_cnt - xfer0), 32'(NB));
      repeat (20) @(negedge clk);
      chk("single_done", 32'(done_cnt - done0), 32'd1);
   endtask

   task automatic wait_xfers(input int xfer0, input int n);
      int cyc = 0;
      while (((xfer_cnt - xfer0) < n || !byte_valid_out) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 30000) chk("xfer_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int d0, x0;
      for (int i = 0; i < PIX; i++) rnd_img[i] = 1'($urandom_range(0, 1));

      #3;
      chk("rst_busy", {31'd0, busy_out}, 32'd0);
      chk("rst_done", {31'd0, done_out}, 32'd0);
      chk("rst_valid", {31'd0, byte_valid_out}, 32'd0);
      chk("rst_byte", {24'd0, byte_out}, 32'd0);
      chk("rst_addr", {15'd0, rd_addr_out}, 32'd0);
      repeat (3) @(negedge clk);
      rst_in_n = 1'b1;

      // Alternating pixels, ready always high.
      pix_mode = 0; ready_pct = 100;
      d0 = done_cnt; x0 = xfer_cnt;
      start_frame();
      wait_done(d0, x0);

      // All-ones frame, ready high about 30% of cycles.
      pix_mode = 1; ready_pct = 30;
      d0 = done_cnt; x0 = xfer_cnt;
      start_frame();
      wait_done(d0, x0);

      // Single dark pixel at address 8; the read address must sweep 8..15.
      pix_mode = 2; ready_pct = 100;
      d0 = done_cnt; x0 = xfer_cnt;
      start_frame();
      begin
         int cyc = 0;
         while (rd_addr_out != 17'd8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         chk("sweep_start", {15'd0, rd_addr_out}, 32'd8);
         for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk("sweep_addr", {15'd0, rd_addr_out}, 32'(8 + i));
         end
      end
      wait_done(d0, x0);

      // Random image; a second start while busy must be ignored.
      pix_mode = 3; ready_pct = 70;
      d0 = done_cnt; x0 = xfer_cnt;
      start_frame();
      wait_xfers(x0, 100);
      @(posedge clk); #1 start_in = 1'b1;
      @(posedge clk); #1 start_in = 1'b0;
      wait_done(d0, x0);

      // Reset in the middle of a data byte, then a fresh frame.
      pix_mode = 3; ready_pct = 50;
      x0 = xfer_cnt;
      start_frame();
      wait_xfers(x0, 500);
      #2 rst_in_n = 1'b0;
      #1;
      chk("async_busy", {31'd0, busy_out}, 32'd0);
      chk("async_done", {31'd0, done_out}, 32'd0);
      chk("async_valid", {31'd0, byte_valid_out}, 32'd0);
      chk("async_byte", {24'd0, byte_out}, 32'd0);
      chk("async_addr", {15'd0, rd_addr_out}, 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_in_n = 1'b1;
      d0 = done_cnt; x0 = xfer_cnt;
      start_frame();
      wait_done(d0, x0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
